// File: rtl/nibble_add_seq.sv
// nibble_add_seq: sequences an N-byte unsigned add through a shared 4-bit
// nibble adder (nibbleadd). The low nibble of each byte is added first,
// then the high nibble. The carry ripples between steps and the wide
// result builds up one nibble at a time. nibbleadd is the combinational
// stage that this sequencer drives.

// nibbleadd: adds the selected nibbles of two bytes.
// ctrl = 0 selects the low nibbles; ctrl = 1 selects the high nibbles.
module nibbleadd (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ctrl,
  output logic [4:0] q
);

  // Pick the nibble pair and add it, keeping the carry in bit 4.
  always_comb begin
    q = 5'd0;
    if (ctrl) q = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    else      q = {1'b0, a[3:0]} + {1'b0, b[3:0]};
  end

endmodule

module nibble_add_seq #(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] a_in,
  input  logic [8*NBYTES-1:0] b_in,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES:0]   sum,
  output logic [7:0]          adder_a,
  output logic [7:0]          adder_b,
  output logic                adder_ctrl,
  input  logic [4:0]          adder_q
);

  localparam int W    = 8 * NBYTES;
  localparam int NNIB = 2 * NBYTES;
  // The byte index is kept at least one bit wide so that NBYTES = 1 still
  // produces legal vectors.
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SELW = IDXW + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_sh, b_sh;      // latched operands, shifted one byte per HI
  logic [W-1:0]    a_nxt, b_nxt;
  logic [IDXW-1:0] idx;
  logic            c;
  logic [W-1:0]    acc, acc_next;
  logic [4:0]      t;
  logic [SELW-1:0] nib_sel;
  logic            accept, capture, last;

  assign busy = (state == LO) || (state == HI);
  assign done = (state == DONE);

  // Decode the per-cycle controls and fold the running carry into the nibble sum.
  always_comb begin
    accept  = start && ((state == IDLE) || (state == DONE));
    capture = (state == LO) || (state == HI);
    last    = (idx == LAST_IDX);
    t       = adder_q + {4'd0, c};
    nib_sel = {idx, (state == HI)};
    a_nxt   = a_sh >> 8;
    b_nxt   = b_sh >> 8;
  end

  // Merge the new nibble into its slot of the working sum.
  // Each nibble position has its own comparator, so no variable part-select is needed.
  genvar gi;
  generate
    for (gi = 0; gi < NNIB; gi++) begin : g_nib
      assign acc_next[4*gi +: 4] = (capture && (nib_sel == SELW'(gi))) ? t[3:0]
                                                                      : acc[4*gi +: 4];
    end
  endgenerate

  // Next-state logic: LO/HI alternate once per byte. DONE can chain
  // directly into a new operation.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LO;
      LO:   state_next = HI;
      HI:   state_next = last ? DONE : LO;
      DONE: state_next = start ? LO : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: operand latch, adder drive registers, carry, accumulator and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      idx        <= '0;
      c          <= 1'b0;
      acc        <= '0;
      sum        <= '0;
      adder_a    <= 8'h00;
      adder_b    <= 8'h00;
      adder_ctrl <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_sh       <= a_in;
            b_sh       <= b_in;
            adder_a    <= a_in[7:0];
            adder_b    <= b_in[7:0];
            adder_ctrl <= 1'b0;
            idx        <= '0;
            c          <= 1'b0;
            acc        <= '0;
          end else begin
            adder_a    <= 8'h00;
            adder_b    <= 8'h00;
            adder_ctrl <= 1'b0;
          end
        end
        LO: begin
          acc        <= acc_next;
          c          <= t[4];
          adder_ctrl <= 1'b1;
        end
        HI: begin
          acc        <= acc_next;
          c          <= t[4];
          adder_ctrl <= 1'b0;
          if (last) begin
            sum     <= {t[4], acc_next};
            adder_a <= 8'h00;
            adder_b <= 8'h00;
          end else begin
            idx     <= idx + 1'b1;
            a_sh    <= a_nxt;
            b_sh    <= b_nxt;
            adder_a <= a_nxt[7:0];
            adder_b <= b_nxt[7:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-cycle sequencer that performs an N-byte unsigned addition by time-multiplexing the existing combinational `nibbleadd` stage. It sits directly around that stage: upstream, it drives the adder's byte operands and nibble select; downstream, it consumes the adder's 5-bit nibble sum, ripples the carry, and assembles the full-width result. Host logic issues one `start` pulse per operation and receives a one-cycle `done` strobe.

## Interface
- NBYTES, 2, operand width in bytes; operands are 8*NBYTES bits, result is 8*NBYTES+1 bits; legal range 1..8
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a_in  input  8*NBYTES  operand A, latched on accepted start
- b_in  input  8*NBYTES  operand B, latched on accepted start
- busy  output  1  high while in LO or HI state
- done  output  1  one-cycle pulse; sum valid
- sum  output  8*NBYTES+1  result {carry_out, A+B}; held until next completion
- adder_a  output  8  byte of A driven to nibbleadd A
- adder_b  output  8  byte of B driven to nibbleadd B
- adder_ctrl  output  1  nibbleadd ctrl; 0 = low nibbles, 1 = high nibbles
- adder_q  input  5  nibbleadd q = selected nibble of adder_a + selected nibble of adder_b (zero-extended)

## Operation
- States: IDLE, LO, HI, DONE. Internal byte index `idx` (0..NBYTES-1), carry flag `c`, working register `acc`.
- IDLE: busy=0, done=0, adder_a=adder_b=8'h00, adder_ctrl=0. When start=1, latch a_in/b_in, set idx=0, c=0, clear acc, and go to LO.
- LO: adder_a/adder_b = byte idx of latched A/B; adder_ctrl=0. Compute t = adder_q + c (5 bits). Capture acc nibble 2*idx = t[3:0] and c = t[4]. Go to HI.
- HI: same bytes, adder_ctrl=1. Same capture into nibble 2*idx+1. If idx=NBYTES-1, set sum = {c_new, acc_new} and go to DONE; otherwise increment idx and go to LO.
- DONE: done=1 for exactly this cycle, busy=0, adder outputs as in IDLE. If start=1, accept it as in IDLE (back-to-back operation); otherwise go to IDLE.
- Arithmetic: adder_q ≤ 30, and adder_q + c ≤ 31 fits in 5 bits. The carry into nibble 0 is 0. The final carry becomes sum MSB.
- start while busy is ignored; a_in/b_in changes during busy have no effect.
- The block treats adder_q as purely combinational from adder_a/adder_b/adder_ctrl within the same cycle.

## Timing
- Reset (asynchronous, any state, including mid-operation): state=IDLE, busy=0, done=0, sum=0, adder_a=adder_b=0, adder_ctrl=0, idx=0, c=0, acc=0. The in-flight operation is discarded and no done is issued.
- Adder outputs are registered state decodes; they are stable for the whole LO/HI cycle.
- start accepted at edge E0 → LO/HI occupy cycles E0..E(2*NBYTES); sum updates and done rises at edge E(2*NBYTES); done falls at E(2*NBYTES+1).
- Latency from accepting edge to done = 2*NBYTES cycles. Throughput = one operation per 2*NBYTES+1 cycles with start held in DONE.
- adder_ctrl sequence per operation: 0,1 repeated NBYTES times; idx advances after each HI.
- sum changes only at the done edge and on reset.

## Test plan
- NBYTES=2, a_in=16'h0924, b_in=16'h6381, one start pulse → adder_a sequence 24,24,09,09; adder_ctrl sequence 0,1,0,1; done at start+4 cycles; sum=17'h06CA5.
- NBYTES=2, a_in=16'h0FFF, b_in=16'h0001 → carry ripples through three nibbles; sum=17'h01000. Then a_in=b_in=16'hFFFF → sum=17'h1FFFE.
- NBYTES=1, a_in=8'h8D, b_in=8'h0D → done 2 cycles after start; sum=9'h09A. Then a_in=8'hF9, b_in=8'hC6 → sum=9'h1BF.
- start re-pulsed mid-operation with different operands → ignored; the original sum is produced with no extra done. start held high through DONE → the next operation begins immediately, and done pulses every 5 cycles (NBYTES=2).
- rst asserted asynchronously during the HI state of operation 16'h1234+16'h1111 → busy, done, sum, adder_a, adder_b, and adder_ctrl all go to 0 immediately. After release, a fresh start yields sum=17'h02345.
- Bench instantiates real nibbleadd wired to adder_a/adder_b/adder_ctrl/adder_q and compares every sum against a+b over 200 random operand pairs.
